// File: rtl/ins_mem_loader_pkg.sv
// ----------------------------------------------------------------------------
// ins_mem_loader_pkg
// Shared definitions for the instruction-memory loader:
//   WORD_W        - instruction word width (32)
//   OP_HALT       - opcode field value of the program's halt instruction
//   loaderState_t - loader state encoding (2 bits)
//   isHalt()      - true when a word carries the halt opcode in [31:26]
// ----------------------------------------------------------------------------
package ins_mem_loader_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        WRITE   = 2'b10,
        DONE    = 2'b11
    } loaderState_t;

    function automatic logic isHalt(input logic [WORD_W-1:0] word);
        return (word[WORD_W-1 -: 6] == OP_HALT);
    endfunction

endpackage

// File: rtl/ins_mem_loader_if.sv
// ----------------------------------------------------------------------------
// ins_mem_loader_if
// Byte-stream input plus instruction-memory write bus of the loader.
//   ByteIn/ByteValid/ByteReady - valid/ready byte stream into the loader
//   InsMemRw/MemWrEn/MemAddr/MemDataOut - instruction-memory side
// Modports: master = loader, slave = byte source / memory model.
// Parameter ADDR_W: instruction-memory byte-address width.
// ----------------------------------------------------------------------------
interface ins_mem_loader_if #(
    parameter int ADDR_W = 8
);
    import ins_mem_loader_pkg::*;

    logic [7:0]        ByteIn;
    logic              ByteValid;
    logic              ByteReady;
    logic              InsMemRw;
    logic              MemWrEn;
    logic [ADDR_W-1:0] MemAddr;
    logic [WORD_W-1:0] MemDataOut;

    modport master (
        input  ByteIn, ByteValid,
        output ByteReady, InsMemRw, MemWrEn, MemAddr, MemDataOut
    );

    modport slave (
        output ByteIn, ByteValid,
        input  ByteReady, InsMemRw, MemWrEn, MemAddr, MemDataOut
    );

endinterface

// File: rtl/ins_mem_loader_word_assembler.sv
// ----------------------------------------------------------------------------
// word_assembler
// Big-endian 4-byte insert register: byte 0 lands in [31:24], byte 3 in [7:0].
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   clear         - synchronous clear of word and byte index (load start)
//   byteEn        - a byte transfers this cycle
//   byteIn        - byte to insert
//   word          - assembled word (registered)
//   wordComplete  - the current transfer fills the last byte slot
// ----------------------------------------------------------------------------
module word_assembler
    import ins_mem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byteEn,
    input  logic [7:0]        byteIn,
    output logic [WORD_W-1:0] word,
    output logic              wordComplete
);

    logic [1:0] byteIdx;

    assign wordComplete = byteEn && (byteIdx == 2'd3);

    // Insert accepted bytes at the slot selected by the byte index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word    <= {WORD_W{1'b0}};
            byteIdx <= 2'd0;
        end else if (clear) begin
            word    <= {WORD_W{1'b0}};
            byteIdx <= 2'd0;
        end else if (byteEn) begin
            case (byteIdx)
                2'd0:    word[31:24] <= byteIn;
                2'd1:    word[23:16] <= byteIn;
                2'd2:    word[15:8]  <= byteIn;
                2'd3:    word[7:0]   <= byteIn;
                default: word        <= {WORD_W{1'b0}};
            endcase
            byteIdx <= byteIdx + 2'd1;
        end
    end

endmodule

// File: rtl/ins_mem_loader.sv
// ----------------------------------------------------------------------------
// ins_mem_loader
// Streams a program into instruction memory, one big-endian 32-bit word at a
// time, at consecutive word addresses from 0. The CPU is held until the halt
// word (opcode 6'b111111) has been written, or memory fills (Overflow).
// Ports:
//   CLK, Reset - clock, asynchronous active-high reset
//   Start      - load start pulse (honoured only in IDLE or DONE)
//   bus        - byte stream in + instruction-memory write bus (master)
//   CpuHold    - CPU stall, released on entering DONE
//   Busy       - load in progress (COLLECT or WRITE)
//   Done       - load complete (sticky until next Start)
//   Overflow   - memory filled before a halt word (sticky until next Start)
//   Checksum   - running XOR of written words when LOADER_CHECKSUM_EN is
//                defined, otherwise constant 0
// Parameter ADDR_W: byte-address width; capacity 2^(ADDR_W-2) words.
// Optional feature macro: LOADER_CHECKSUM_EN.
// ----------------------------------------------------------------------------
module ins_mem_loader
    import ins_mem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Start,
    ins_mem_loader_if.master   bus,
    output logic               CpuHold,
    output logic               Busy,
    output logic               Done,
    output logic               Overflow,
    output logic [WORD_W-1:0]  Checksum
);

    localparam int WADDR_W = ADDR_W - 2;

    loaderState_t       state;
    logic [WADDR_W-1:0] wordAddr;
    logic [WORD_W-1:0]  asmWord;
    logic               startAccept;
    logic               byteXfer;
    logic               wordComplete;
    logic               lastWord;
    logic               haltWord;

    // ByteReady is a registered state decode, so no path from ByteValid
    // reaches any output.
    assign startAccept = Start && ((state == IDLE) || (state == DONE));
    assign byteXfer    = bus.ByteValid && bus.ByteReady;
    assign lastWord    = (wordAddr == {WADDR_W{1'b1}});
    assign haltWord    = isHalt(asmWord);

    assign bus.MemAddr    = {wordAddr, 2'b00};
    assign bus.MemDataOut = asmWord;

    word_assembler u_word_assembler (
        .clk          (CLK),
        .rst          (Reset),
        .clear        (startAccept),
        .byteEn       (byteXfer),
        .byteIn       (bus.ByteIn),
        .word         (asmWord),
        .wordComplete (wordComplete)
    );

    // Loader state machine with registered outputs and word-address counter.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            wordAddr      <= {WADDR_W{1'b0}};
            bus.ByteReady <= 1'b0;
            bus.InsMemRw  <= 1'b1;
            bus.MemWrEn   <= 1'b0;
            CpuHold       <= 1'b1;
            Busy          <= 1'b0;
            Done          <= 1'b0;
            Overflow      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state         <= COLLECT;
                        wordAddr      <= {WADDR_W{1'b0}};
                        bus.ByteReady <= 1'b1;
                        bus.InsMemRw  <= 1'b1;
                        CpuHold       <= 1'b1;
                        Busy          <= 1'b1;
                        Done          <= 1'b0;
                        Overflow      <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (wordComplete) begin
                        state         <= WRITE;
                        bus.ByteReady <= 1'b0;
                        bus.InsMemRw  <= 1'b0;
                        bus.MemWrEn   <= 1'b1;
                    end
                end
                WRITE: begin
                    bus.MemWrEn  <= 1'b0;
                    bus.InsMemRw <= 1'b1;
                    wordAddr     <= wordAddr + {{(WADDR_W-1){1'b0}}, 1'b1};
                    // Halt wins over a simultaneous wrap: Overflow stays 0.
                    if (haltWord) begin
                        state   <= DONE;
                        CpuHold <= 1'b0;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                    end else if (lastWord) begin
                        state    <= DONE;
                        CpuHold  <= 1'b0;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        Overflow <= 1'b1;
                    end else begin
                        state         <= COLLECT;
                        bus.ByteReady <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    wordAddr      <= {WADDR_W{1'b0}};
                    bus.ByteReady <= 1'b0;
                    bus.InsMemRw  <= 1'b1;
                    bus.MemWrEn   <= 1'b0;
                    CpuHold       <= 1'b1;
                    Busy          <= 1'b0;
                    Done          <= 1'b0;
                    Overflow      <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] checksumReg;

    // Running XOR of every word written since the last accepted Start.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            checksumReg <= {WORD_W{1'b0}};
        end else if (startAccept) begin
            checksumReg <= {WORD_W{1'b0}};
        end else if (state == WRITE) begin
            checksumReg <= checksumReg ^ asmWord;
        end
    end

    assign Checksum = checksumReg;
`else
    assign Checksum = {WORD_W{1'b0}};
`endif

endmodule

// File: doc/ins_mem_loader.md
# ins_mem_loader

Writes a program into instruction memory one 32-bit word at a time. Bytes arrive over a valid/ready byte stream, are assembled big-endian, and are written to consecutive word addresses starting at 0. It is the write-side counterpart of the decode path: the decode path reads instructions with InsMemRw = 1, and this block drives InsMemRw = 0. It holds the CPU stalled until the program's halt instruction (opcode 6'b111111) has been stored.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory byte-address width; capacity is 2^(ADDR_W-2) words.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  single-cycle pulse that begins a load; sampled only in IDLE or DONE.
- ByteIn  in  8  stream data byte.
- ByteValid  in  1  ByteIn is valid.
- ByteReady  out  1  loader accepts a byte this cycle.
- InsMemRw  out  1  0 = write instruction memory, 1 = read.
- MemWrEn  out  1  write strobe, one cycle per word.
- MemAddr  out  ADDR_W  byte address of the word being written; always a multiple of 4.
- MemDataOut  out  32  instruction word to write.
- CpuHold  out  1  1 = CPU stalled (PC write inhibited).
- Busy  out  1  a load is in progress (COLLECT or WRITE).
- Done  out  1  load complete; sticky.
- Overflow  out  1  memory filled before a halt word arrived; sticky.
- Checksum  out  32  see Configuration.

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - CpuHold = 1, ByteReady = 0.
  - Start: clears the address, byte index, Done and Overflow, then goes to COLLECT.
- COLLECT:
  - ByteReady = 1.
  - A byte transfers when ByteValid && ByteReady.
  - Byte 0 goes to bits [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
  - Accepting byte 3 moves the state to WRITE.
- WRITE (exactly one cycle):
  - ByteReady = 0, InsMemRw = 0, MemWrEn = 1.
  - MemAddr is the current address; MemDataOut is the assembled word.
  - Next cycle, the address advances by 4. Next state:
    - DONE if word[31:26] == 6'b111111.
    - Otherwise DONE with Overflow = 1 if the address wraps to 0 (last word written).
    - Otherwise back to COLLECT.
  - When both conditions hold, the halt word takes precedence and Overflow stays 0.
- DONE:
  - Done = 1, CpuHold = 0, InsMemRw = 1.
  - Start restarts a load from address 0.
- Start outside IDLE/DONE is ignored.
- Bytes presented while ByteReady = 0 are not consumed.
- Reset mid-load returns to IDLE and discards any partial word. Words already written to memory are untouched.

## Timing
- Reset values:
  - State IDLE; ByteReady 0, InsMemRw 1, MemWrEn 0.
  - MemAddr 0, MemDataOut 0.
  - CpuHold 1, Busy 0, Done 0, Overflow 0, Checksum 0.
- All outputs are registered or decoded directly from state; no combinational path from ByteValid to any output.
- Back-to-back bytes: one word costs 4 accept cycles plus 1 WRITE cycle, so minimum throughput is 5 cycles per word.
- CpuHold falls on the clock edge that enters DONE, one cycle after the halt word's MemWrEn.
- Start in IDLE: ByteReady rises on the next cycle.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - Checksum is the running XOR of every word written since the last Start.
  - It is cleared by Start and by Reset, and updated in the WRITE cycle.
- Undefined: Checksum is constant 0 and no XOR logic is built.

## Structure
- Shared package holds:
  - OP_HALT = 6'b111111.
  - The loader state enumeration (2-bit encoding).
  - The word width constant, 32.
- One sub-module, word_assembler:
  - A 4-byte big-endian shift/insert register with a 2-bit byte index and a "word complete" flag.
  - Cleared by Start and by Reset.
- Address counter, state machine and optional checksum stay in ins_mem_loader.

## Test plan
- Reset, Start, then stream bytes 02 41 00 00, FC 00 00 00:
  - Writes 0x02410000 at addr 0 and 0xFC000000 at addr 4.
  - Done = 1 and CpuHold = 0 one cycle after the second write.
- ByteValid toggled every other cycle during a 4-byte word:
  - Exactly one MemWrEn, with the correct word.
  - No bytes dropped or duplicated.
- ADDR_W = 4, stream 4 non-halt words:
  - Writes at 0, 4, 8, 12.
  - Then DONE with Overflow = 1 and MemAddr = 0.
- Reset asserted after 2 bytes of the second word:
  - IDLE immediately; all outputs at reset values; no further writes.
  - Following Start plus a halt word writes at addr 0.
- Start pulsed in COLLECT:
  - Ignored; the load continues at the same address.
- With LOADER_CHECKSUM_EN, write 0x12345678 then 0xFC000001:
  - Checksum = 0xEE345679.
- Without LOADER_CHECKSUM_EN, same stream:
  - Checksum = 0.
